seg14_scroller: RTL and testbench

Text-scroll source for the board's 14-segment display. A host-side loader writes an ASCII message one byte per handshake into a small buffer. The block then loops the message onto the active-low `disp` bus: each character is shown for one divided-clock period, followed by one blank period. It replaces the fixed-pattern generator upstream of the display pins and keeps the same `disp` polarity and blank code.

---
 rtl/seg14_scroller.sv | 178 +++++++++++++++++
 tb/tb_seg14_scroller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg14_scroller.sv
// rtl/seg14_scroller.sv - ASCII message buffer scrolled onto an active-low 14-segment display
module seg14_scroller #(
  parameter int CLK_DIV_W = 25,
  parameter int BUF_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [7:0]                   wr_data,
  input  logic                         wr_last,
  input  logic                         stop,
  output logic [13:0]                  disp,
  output logic                         busy,
  output logic [$clog2(BUF_DEPTH)-1:0] char_idx
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_GAP
  } state_t;

  state_t             r_state;
  logic [CLK_DIV_W-1:0] r_div;
  logic               r_tick;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_char_idx;
  logic [13:0]        r_disp;
  logic               r_busy;
  logic [7:0]         r_buf [BUF_DEPTH];

  logic               w_xfer;
  logic [IDX_W-1:0]   w_wr_addr;
  logic [7:0]         w_ch;
  logic [13:0]        w_glyph;

  // Loader may push while idle, or while loading and the buffer still has room.
  assign wr_ready  = (r_state == ST_IDLE) ||
                     ((r_state == ST_LOAD) && (r_count < CNT_W'(BUF_DEPTH)));
  // A stop in the same cycle discards the offered byte.
  assign w_xfer    = wr_valid && wr_ready && !stop;
  assign w_wr_addr = (r_state == ST_IDLE) ? '0 : r_count[IDX_W-1:0];

  assign disp     = r_disp;
  assign busy     = r_busy;
  assign char_idx = r_char_idx;

  // Free-running divider; tick pulses the cycle after the counter passes zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= r_div + CLK_DIV_W'(1);
      r_tick <= (r_div == '0);
    end
  end

  // Message storage; contents survive reset and are only meaningful below len.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_buf[w_wr_addr] <= wr_data;
    end
  end

  // Font ROM: lower case folds to upper, space is blank, anything else is a dash.
  always_comb begin
    w_ch = r_buf[r_char_idx];
    if ((w_ch >= 8'h61) && (w_ch <= 8'h7A)) begin
      w_ch = w_ch - 8'h20;
    end
    case (w_ch)
      8'h20: w_glyph = 14'h0000;
      8'h30: w_glyph = 14'h0C3F;
      8'h31: w_glyph = 14'h0006;
      8'h32: w_glyph = 14'h00DB;
      8'h33: w_glyph = 14'h008F;
      8'h34: w_glyph = 14'h00E6;
      8'h35: w_glyph = 14'h2069;
      8'h36: w_glyph = 14'h00FD;
      8'h37: w_glyph = 14'h0007;
      8'h38: w_glyph = 14'h00FF;
      8'h39: w_glyph = 14'h00EF;
      8'h41: w_glyph = 14'h00F7;
      8'h42: w_glyph = 14'h128F;
      8'h43: w_glyph = 14'h0039;
      8'h44: w_glyph = 14'h120F;
      8'h45: w_glyph = 14'h00F9;
      8'h46: w_glyph = 14'h0071;
      8'h47: w_glyph = 14'h00BD;
      8'h48: w_glyph = 14'h00F6;
      8'h49: w_glyph = 14'h1209;
      8'h4A: w_glyph = 14'h001E;
      8'h4B: w_glyph = 14'h2470;
      8'h4C: w_glyph = 14'h0038;
      8'h4D: w_glyph = 14'h0536;
      8'h4E: w_glyph = 14'h2136;
      8'h4F: w_glyph = 14'h003F;
      8'h50: w_glyph = 14'h00F3;
      8'h51: w_glyph = 14'h203F;
      8'h52: w_glyph = 14'h20F3;
      8'h53: w_glyph = 14'h018D;
      8'h54: w_glyph = 14'h1201;
      8'h55: w_glyph = 14'h003E;
      8'h56: w_glyph = 14'h0C30;
      8'h57: w_glyph = 14'h2836;
      8'h58: w_glyph = 14'h2D00;
      8'h59: w_glyph = 14'h1500;
      8'h5A: w_glyph = 14'h0C09;
      default: w_glyph = 14'h00C0;
    endcase
  end

  // Control FSM; disp/busy are registered from the state so they lag it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_len      <= CNT_W'(1);
      r_char_idx <= '0;
      r_disp     <= 14'h3FFF;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_SHOW) || (r_state == ST_GAP);
      r_disp <= (r_state == ST_SHOW) ? ~w_glyph : 14'h3FFF;
      if (stop) begin
        r_state    <= ST_IDLE;
        r_count    <= '0;
        r_char_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_xfer) begin
              r_count <= CNT_W'(1);
              if (wr_last) begin
                r_len      <= CNT_W'(1);
                r_char_idx <= '0;
                r_state    <= ST_SHOW;
              end else begin
                r_state <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            if (w_xfer) begin
              r_count <= r_count + CNT_W'(1);
              if (wr_last) begin
                r_len      <= r_count + CNT_W'(1);
                r_char_idx <= '0;
                r_state    <= ST_SHOW;
              end
            end
          end
          ST_SHOW: begin
            if (r_tick) begin
              r_state <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (r_tick) begin
              r_char_idx <= (({1'b0, r_char_idx} + CNT_W'(1)) == r_len) ?
                            '0 : r_char_idx + IDX_W'(1);
              r_state    <= ST_SHOW;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg14_scroller.sv
// tb/tb_seg14_scroller.sv - randomized self-checking bench for seg14_scroller
module tb_seg14_scroller;
  localparam int DW = 4;
  localparam int BD = 16;
  localparam int P  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_last = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready;
  logic        busy;
  logic [13:0] disp;
  logic [3:0]  char_idx;

  int checks = 0;
  int errors = 0;
  int cyc;
  int last_edge;
  int m_start;
  logic [7:0] m_msg[$];

  seg14_scroller #(.CLK_DIV_W(DW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .stop(stop), .disp(disp),
    .busy(busy), .char_idx(char_idx)
  );

  always #5 clk = ~clk;

  // Edge index since reset release: first posedge after release is 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] model_glyph(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h31:   return 14'h0006;
      8'h38:   return 14'h00FF;
      8'h41:   return 14'h00F7;
      8'h20:   return 14'h0000;
      default: return 14'h00C0;
    endcase
  endfunction

  // Number of phase-change edges (SHOW<->GAP) among edges 1..x.
  function automatic int ph_edges(input int x);
    return (x >= 2) ? ((x - 2) / P + 1) : 0;
  endfunction

  function automatic logic [13:0] exp_disp(input int t);
    int p;
    p = ph_edges(t - 1) - ph_edges(m_start);
    if (p % 2 == 1) return 14'h3FFF;
    return ~model_glyph(m_msg[(p / 2) % m_msg.size()]);
  endfunction

  function automatic logic [3:0] exp_idx(input int t);
    int q;
    q = ph_edges(t) - ph_edges(m_start);
    return 4'((q / 2) % m_msg.size());
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_last = 1'b0; stop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    wr_valid = 1'b1; wr_data = b; wr_last = l;
    @(negedge clk);
    last_edge = cyc;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (disp !== 14'h3FFF) begin errors++; $display("FAIL reset_disp got=%h exp=3fff", disp); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (char_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", char_idx); end
    repeat (3) @(negedge clk);
    checks++;
    if (disp !== 14'h3FFF || busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL idle_hold disp=%h busy=%b ready=%b exp 3fff/0/1", disp, busy, wr_ready);
    end
  endtask

  task automatic test_single;
    int seen;
    seen = 0;
    m_msg = {8'h31};
    send_byte(8'h31, 1'b1);
    m_start = last_edge;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (disp === 14'h3FF9) seen++;
      checks++;
      if (disp !== exp_disp(cyc) || char_idx !== exp_idx(cyc) || busy !== 1'b1 || wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL single cyc=%0d disp=%h exp=%h idx=%0d exp=%0d busy=%b ready=%b",
                 cyc, disp, exp_disp(cyc), char_idx, exp_idx(cyc), busy, wr_ready);
      end
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL single_seen got=0 exp>0 cycles of 3ff9"); end
    pulse_stop();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stop_ready got=%b exp=1", wr_ready); end
    @(negedge clk);
    checks++;
    if (disp !== 14'h3FFF || busy !== 1'b0 || char_idx !== 4'd0) begin
      errors++; $display("FAIL stop_outputs disp=%h busy=%b idx=%0d exp 3fff/0/0", disp, busy, char_idx);
    end
  endtask

  task automatic test_multi;
    m_msg = {8'h41, 8'h38, 8'h61};
    send_byte(8'h41, 1'b0);
    send_byte(8'h38, 1'b0);
    send_byte(8'h61, 1'b1);
    m_start = last_edge;
    for (int k = 0; k < 7 * P + 3; k++) begin
      @(negedge clk);
      checks++;
      if (disp !== exp_disp(cyc) || char_idx !== exp_idx(cyc) || busy !== 1'b1) begin
        errors++;
        $display("FAIL multi cyc=%0d disp=%h exp=%h idx=%0d exp=%0d busy=%b",
                 cyc, disp, exp_disp(cyc), char_idx, exp_idx(cyc), busy);
      end
    end
    pulse_stop();
    @(negedge clk);
  endtask

  task automatic test_full;
    for (int i = 0; i < BD; i++) begin
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got=%b exp=1", i, wr_ready); end
      send_byte(8'($urandom_range(33, 90)), 1'b0);
    end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop got=%b exp=0", wr_ready); end
    wr_valid = 1'b1; wr_data = 8'h31; wr_last = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b0 || disp !== 14'h3FFF) begin
        errors++; $display("FAIL full_wait ready=%b busy=%b disp=%h exp 0/0/3fff", wr_ready, busy, disp);
      end
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    pulse_stop();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_stop_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_glyphs;
    m_msg = {8'h23};
    send_byte(8'h23, 1'b1);
    m_start = last_edge;
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      checks++;
      if (disp !== exp_disp(cyc)) begin
        errors++; $display("FAIL hash cyc=%0d disp=%h exp=%h", cyc, disp, exp_disp(cyc));
      end
    end
    pulse_stop();
    @(negedge clk);
    m_msg = {8'h20};
    send_byte(8'h20, 1'b1);
    m_start = last_edge;
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      checks++;
      if (disp !== 14'h3FFF || busy !== 1'b1) begin
        errors++; $display("FAIL space cyc=%0d disp=%h busy=%b exp 3fff/1", cyc, disp, busy);
      end
    end
    pulse_stop();
    @(negedge clk);
  endtask

  task automatic test_stop_xfer;
    send_byte(8'h41, 1'b0);
    send_byte(8'h38, 1'b0);
    wr_valid = 1'b1; wr_data = 8'h23; wr_last = 1'b0;
    pulse_stop();
    wr_valid = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stopx_ready got=%b exp=1", wr_ready); end
    m_msg = {8'h31};
    send_byte(8'h31, 1'b1);
    m_start = last_edge;
    for (int k = 0; k < 4 * P; k++) begin
      @(negedge clk);
      checks++;
      if (disp !== exp_disp(cyc) || char_idx !== 4'd0) begin
        errors++; $display("FAIL stopx_play cyc=%0d disp=%h exp=%h idx=%0d exp=0", cyc, disp, exp_disp(cyc), char_idx);
      end
    end
    pulse_stop();
    @(negedge clk);
  endtask

  task automatic test_random;
    int len;
    logic [7:0] c;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, BD);
      m_msg = {};
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 5))
          0: c = 8'h31;
          1: c = 8'h38;
          2: c = 8'h41;
          3: c = 8'h61;
          4: c = 8'h20;
          default: c = 8'($urandom_range(33, 47));
        endcase
        m_msg.push_back(c);
      end
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(m_msg[i], (i == len - 1));
      end
      m_start = last_edge;
      for (int k = 0; k < 2 * len * P + 2 * P; k++) begin
        @(negedge clk);
        checks++;
        if (disp !== exp_disp(cyc) || char_idx !== exp_idx(cyc) || busy !== 1'b1) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d disp=%h exp=%h idx=%0d exp=%0d busy=%b",
                   it, cyc, disp, exp_disp(cyc), char_idx, exp_idx(cyc), busy);
        end
      end
      pulse_stop();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || disp !== 14'h3FFF || char_idx !== 4'd0) begin
        errors++; $display("FAIL random_stop it=%0d busy=%b disp=%h idx=%0d", it, busy, disp, char_idx);
      end
    end
  endtask

  task automatic test_async_reset;
    m_msg = {8'h41, 8'h38};
    send_byte(8'h41, 1'b0);
    send_byte(8'h38, 1'b1);
    repeat (2 * P + 5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (disp !== 14'h3FFF) begin errors++; $display("FAIL arst_disp got=%h exp=3fff", disp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (char_idx !== 4'd0) begin errors++; $display("FAIL arst_idx got=%0d exp=0", char_idx); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || disp !== 14'h3FFF) begin
      errors++; $display("FAIL arst_after busy=%b disp=%h exp 0/3fff", busy, disp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_glyphs();
    test_stop_xfer();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
